prog_frame_loader: RTL and testbench

Framed, checksummed program loader between the programming UART receiver and the ICCM write port. It consumes bytes from the UART byte receiver and assembles framed records into 32-bit words. It issues word writes to the instruction-memory adapter, holds the system in reset while a programming session is open, and returns an ACK/NAK byte per frame for a UART transmitter. It is the robust successor to the unframed word streamer on the same path.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_frame_loader_if.sv | 19 +
 rtl/prog_word_asm.sv | 30 +++
 rtl/prog_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_frame_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, response bytes and default frame markers
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN,
    S_DATA,
    S_CKSUM,
    S_RESP
  } state_e;
  localparam logic [7:0] ACK_BYTE    = 8'h06;
  localparam logic [7:0] NAK_BYTE    = 8'h15;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] EOP_DEFAULT = 8'h5A;
endpackage

// File: rtl/prog_frame_loader_if.sv
// prog_frame_loader_if: UART byte in, ICCM write port and response byte out
interface prog_frame_loader_if;
  logic        rx_dv_i;
  logic [7:0]  rx_byte_i;
  logic        tx_busy_i;
  logic        we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic        tx_dv_o;
  logic [7:0]  tx_byte_o;
  modport master (
    input  rx_dv_i, rx_byte_i, tx_busy_i,
    output we_o, addr_o, wdata_o, tx_dv_o, tx_byte_o
  );
  modport slave (
    output rx_dv_i, rx_byte_i, tx_busy_i,
    input  we_o, addr_o, wdata_o, tx_dv_o, tx_byte_o
  );
endinterface

// File: rtl/prog_word_asm.sv
// prog_word_asm: little-endian byte-to-word assembler with 4th-byte completion strobe
module prog_word_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);
  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;
  assign word_o = {byte_i, sh_q};
  assign done_o = en_i && idx_q == 2'd3;
  // shift each byte in from the top so the first byte lands in the low lane
  always_comb begin
    idx_d = clr_i ? 2'd0 : idx_q + {1'b0, en_i};
    sh_d  = en_i ? {byte_i, sh_q[23:8]} : sh_q;
  end
  // byte index and partial word
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q <= 2'd0;
      sh_q  <= 24'd0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end
endmodule

// File: rtl/prog_frame_loader.sv
// prog_frame_loader: framed UART-to-ICCM program loader; PROG_FRAME_CKSUM_EN adds a verified CKSUM byte
module prog_frame_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter logic [7:0]  EOP_BYTE       = EOP_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic prog_i,
  prog_frame_loader_if.master bus,
  output logic reset_o,
  output logic err_o
);
  state_e      state_q, state_d;
  logic        sess_q, sess_d, eop_q, eop_d, rsto_q, rsto_d, err_q, err_d, we_q, we_d;
  logic [11:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, cnt_q, cnt_d, word;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [7:0]  txb_q, txb_d, b;
  logic        rx, tmo, done, tx_dv, asm_en, asm_clr;
`ifdef PROG_FRAME_CKSUM_EN
  logic [7:0]  sum_q, sum_d, sum_n;
`endif
  assign rx            = bus.rx_dv_i;
  assign b             = bus.rx_byte_i;
  assign bus.we_o      = we_q;
  assign bus.addr_o    = waddr_q;
  assign bus.wdata_o   = wdata_q;
  assign bus.tx_dv_o   = tx_dv;
  assign bus.tx_byte_o = txb_q;
  assign reset_o       = rsto_q;
  assign err_o         = err_q;
  prog_word_asm u_asm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (asm_clr),
    .en_i   (asm_en),
    .byte_i (b),
    .word_o (word),
    .done_o (done)
  );
  // frame parser, session tracking, idle timeout and response selection
  always_comb begin
    state_d = state_q;
    sess_d  = sess_q;
    eop_d   = eop_q;
    err_d   = err_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    txb_d   = txb_q;
    we_d    = 1'b0;
    asm_en  = 1'b0;
    asm_clr = 1'b0;
    tx_dv   = 1'b0;
    cnt_d   = (rx || state_q == S_IDLE || state_q == S_RESP) ? 32'd0 : cnt_q + 32'd1;
    tmo     = !rx && cnt_q >= TIMEOUT_CYCLES && state_q != S_IDLE && state_q != S_RESP;
`ifdef PROG_FRAME_CKSUM_EN
    sum_n   = sum_q + b;
    sum_d   = rx ? sum_n : sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        sess_d = (eop_q && !prog_i) ? 1'b0 : sess_q | prog_i;
        eop_d  = eop_q && prog_i;
        if (sess_q && rx && b == SOF_BYTE) begin
          state_d = S_ADDR_H;
          err_d   = 1'b0;
          eop_d   = 1'b0;
          asm_clr = 1'b1;
`ifdef PROG_FRAME_CKSUM_EN
          sum_d   = 8'd0;
`endif
        end else if (sess_q && rx && b == EOP_BYTE) begin
          state_d = S_RESP;
          txb_d   = ACK_BYTE;
          eop_d   = 1'b1;
        end
      end
      S_ADDR_H: if (rx) begin
        addr_d  = {b[3:0], addr_q[7:0]};
        state_d = S_ADDR_L;
      end
      S_ADDR_L: if (rx) begin
        addr_d  = {addr_q[11:8], b};
        state_d = S_LEN;
      end
      S_LEN: if (rx) begin
        wcnt_d  = {b == 8'd0, b};
        state_d = S_DATA;
      end
      S_DATA: begin
        asm_en = rx;
        if (done) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          addr_d  = addr_q + 12'd1;
          wcnt_d  = wcnt_q - 9'd1;
          if (wcnt_q == 9'd1) begin
`ifdef PROG_FRAME_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_RESP;
            txb_d   = ACK_BYTE;
`endif
          end
        end
      end
`ifdef PROG_FRAME_CKSUM_EN
      S_CKSUM: if (rx) begin
        state_d = S_RESP;
        txb_d   = sum_n == 8'd0 ? ACK_BYTE : NAK_BYTE;
        err_d   = err_q | (sum_n != 8'd0);
      end
`endif
      S_RESP: if (!bus.tx_busy_i) begin
        tx_dv   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    rsto_d = ~sess_d;
  end
  // state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sess_q  <= 1'b0;
      eop_q   <= 1'b0;
      rsto_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      waddr_q <= 12'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 32'd0;
      wcnt_q  <= 9'd0;
      txb_q   <= 8'd0;
`ifdef PROG_FRAME_CKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      sess_q  <= sess_d;
      eop_q   <= eop_d;
      rsto_q  <= rsto_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      txb_q   <= txb_d;
`ifdef PROG_FRAME_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_frame_loader.sv
// tb_prog_frame_loader: randomized frame stimulus against a frame-level write/response model
module tb_prog_frame_loader;
  import prog_loader_pkg::*;
  localparam int T = 40;
`ifdef PROG_FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct {int c; logic [11:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst_ni = 1'b0, prog_i = 1'b0, reset_o, err_o;
  int cyc = 0, tests = 0, fails = 0, tx_cyc = 0;
  wr_t exp_w[$], got_w[$];
  logic [7:0] got_tx[$], exp_tx[$];
  prog_frame_loader_if bus();
  prog_frame_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .prog_i (prog_i),
    .bus    (bus),
    .reset_o(reset_o),
    .err_o  (err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.we_o) got_w.push_back('{cyc, bus.addr_o, bus.wdata_o});
    if (bus.tx_dv_o) begin
      got_tx.push_back(bus.tx_byte_o);
      tx_cyc = cyc;
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] v, output int c);
    bus.rx_dv_i = 1'b1;
    bus.rx_byte_i = v;
    c = cyc;
    @(posedge clk);
    #1;
    bus.rx_dv_i = 1'b0;
  endtask
  task automatic gsend(input logic [7:0] v, input int lo, input int hi, output int c);
    idle(int'($urandom_range(hi, lo)));
    send_byte(v, c);
  endtask
  task automatic wait_tx(input int k);
    for (int i = 0; i < 60 && got_tx.size() <= k; i++) idle(1);
  endtask
  task automatic clear_q;
    exp_w.delete();
    got_w.delete();
    got_tx.delete();
    exp_tx.delete();
  endtask
  task automatic send_frame(input logic [11:0] a, input logic [7:0] len, input bit bad,
                            input int lo, input int hi, output logic [7:0] resp);
    logic [7:0] s, hh, v;
    logic [31:0] w;
    int c, n;
    n = (len == 8'd0) ? 256 : int'(len);
    hh = {4'($urandom), a[11:8]};
    send_byte(SOF_DEFAULT, c);
    gsend(hh, lo, hi, c);
    gsend(a[7:0], lo, hi, c);
    gsend(len, lo, hi, c);
    s = hh + a[7:0] + len;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) begin
        v = w[8*j +: 8];
        gsend(v, lo, hi, c);
        s = s + v;
      end
      exp_w.push_back('{c + 1, 12'(a + 12'(i)), w});
    end
    if (CK) begin
      v = 8'(-s) + {7'd0, bad};
      gsend(v, lo, hi, c);
      s = s + v;
    end
    resp = (!CK || s == 8'd0) ? ACK_BYTE : NAK_BYTE;
  endtask
  task automatic send_plan(input bit bad);
    logic [7:0] fr[8];
    logic [7:0] s;
    int c;
    fr = '{8'h00, 8'h10, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    s = 8'd0;
    for (int i = 0; i < 7; i++) s = s + fr[i];
    fr[7] = 8'(-s) + {7'd0, bad};
    send_byte(SOF_DEFAULT, c);
    for (int i = 0; i < (CK ? 8 : 7); i++) begin
      send_byte(fr[i], c);
      if (i == 6) exp_w.push_back('{c + 1, 12'h010, 32'h12345678});
    end
  endtask
  task automatic test_reset;
    bus.rx_dv_i = 1'b0;
    bus.rx_byte_i = 8'd0;
    bus.tx_busy_i = 1'b0;
    idle(3);
    tests += 7;
    if (bus.we_o !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", bus.we_o); end
    if (bus.addr_o !== 12'd0) begin fails++; $display("FAIL rst_addr got %h exp 000", bus.addr_o); end
    if (bus.wdata_o !== 32'd0) begin fails++; $display("FAIL rst_wdata got %h exp 0", bus.wdata_o); end
    if (bus.tx_dv_o !== 1'b0) begin fails++; $display("FAIL rst_txdv got %b exp 0", bus.tx_dv_o); end
    if (bus.tx_byte_o !== 8'd0) begin fails++; $display("FAIL rst_txbyte got %h exp 00", bus.tx_byte_o); end
    if (reset_o !== 1'b0) begin fails++; $display("FAIL rst_reset_o got %b exp 0", reset_o); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err_o); end
    rst_ni = 1'b1;
    idle(1);
    tests++;
    if (reset_o !== 1'b1) begin fails++; $display("FAIL rst_release_reset_o got %b exp 1", reset_o); end
  endtask
  task automatic test_open;
    prog_i = 1'b1;
    idle(3);
    tests++;
    if (reset_o !== 1'b0) begin fails++; $display("FAIL open_reset_o got %b exp 0", reset_o); end
  endtask
  task automatic test_basic;
    clear_q();
    send_plan(1'b0);
    wait_tx(0);
    tests += 3;
    if (got_w.size() != 1 || got_w[0].c !== exp_w[0].c || got_w[0].a !== 12'h010 || got_w[0].d !== 32'h12345678)
      begin fails++; $display("FAIL basic_write got n=%0d exp one write a=010 d=12345678", got_w.size()); end
    if (got_tx.size() != 1 || got_tx[0] !== ACK_BYTE) begin fails++; $display("FAIL basic_resp got n=%0d exp one 06", got_tx.size()); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", err_o); end
  endtask
  task automatic test_bad_cksum;
    clear_q();
    send_plan(1'b1);
    wait_tx(0);
    tests += 3;
    if (got_w.size() != 1 || got_w[0].c !== exp_w[0].c || got_w[0].a !== 12'h010 || got_w[0].d !== 32'h12345678)
      begin fails++; $display("FAIL bad_write got n=%0d exp one write a=010 d=12345678", got_w.size()); end
    if (got_tx.size() != 1 || got_tx[0] !== (CK ? NAK_BYTE : ACK_BYTE))
      begin fails++; $display("FAIL bad_resp got n=%0d exp one %h", got_tx.size(), CK ? NAK_BYTE : ACK_BYTE); end
    if (err_o !== CK) begin fails++; $display("FAIL bad_err got %b exp %b", err_o, CK); end
  endtask
  task automatic test_wrap;
    logic [7:0] r;
    clear_q();
    send_frame(12'hFFF, 8'd2, 1'b0, 0, 3, r);
    wait_tx(0);
    tests += 4;
    if (got_w.size() != 2 || got_w[0].a !== 12'hFFF || got_w[1].a !== 12'h000)
      begin fails++; $display("FAIL wrap_addr got n=%0d exp writes at fff then 000", got_w.size()); end
    if (got_w.size() != 2 || got_w[0].d !== exp_w[0].d || got_w[1].d !== exp_w[1].d || got_w[1].c !== exp_w[1].c)
      begin fails++; $display("FAIL wrap_data got n=%0d exp 2 matching writes", got_w.size()); end
    if (got_tx.size() != 1 || got_tx[0] !== r) begin fails++; $display("FAIL wrap_resp got n=%0d exp one %h", got_tx.size(), r); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL wrap_err_cleared got %b exp 0", err_o); end
  endtask
  task automatic test_busy;
    logic [7:0] r;
    int m;
    clear_q();
    bus.tx_busy_i = 1'b1;
    send_frame(12'h200, 8'd1, 1'b0, 0, 2, r);
    idle(50);
    tests++;
    if (got_tx.size() != 0) begin fails++; $display("FAIL busy_hold got n=%0d exp 0", got_tx.size()); end
    bus.tx_busy_i = 1'b0;
    m = cyc;
    idle(10);
    tests += 2;
    if (got_tx.size() != 1 || got_tx[0] !== r) begin fails++; $display("FAIL busy_once got n=%0d exp one %h", got_tx.size(), r); end
    if (tx_cyc !== m) begin fails++; $display("FAIL busy_cycle got %0d exp %0d", tx_cyc, m); end
  endtask
  task automatic test_timeout;
    logic [7:0] r;
    int c;
    clear_q();
    send_byte(SOF_DEFAULT, c);
    send_byte(8'h03, c);
    send_byte(8'h40, c);
    idle(T + 1);
    send_byte(8'h01, c);
    idle(8);
    tests += 3;
    if (err_o !== 1'b1) begin fails++; $display("FAIL tmo_err got %b exp 1", err_o); end
    if (got_tx.size() != 0) begin fails++; $display("FAIL tmo_no_resp got n=%0d exp 0", got_tx.size()); end
    if (got_w.size() != 0) begin fails++; $display("FAIL tmo_no_write got n=%0d exp 0", got_w.size()); end
    send_frame(12'h340, 8'd2, 1'b0, T, T, r);
    wait_tx(0);
    tests += 3;
    if (got_tx.size() != 1 || got_tx[0] !== ACK_BYTE) begin fails++; $display("FAIL tmo_recover_resp got n=%0d exp one 06", got_tx.size()); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL tmo_recover_err got %b exp 0", err_o); end
    if (got_w.size() != 2 || got_w[1].a !== exp_w[1].a || got_w[1].d !== exp_w[1].d || got_w[1].c !== exp_w[1].c)
      begin fails++; $display("FAIL tmo_recover_write got n=%0d exp 2", got_w.size()); end
  endtask
  task automatic test_random;
    logic [7:0] r;
    clear_q();
    for (int k = 0; k < 8; k++) begin
      send_frame(12'($urandom), 8'($urandom_range(6, 1)), 1'($urandom), 0, T, r);
      exp_tx.push_back(r);
      wait_tx(k);
      tests++;
      if (err_o !== (r == NAK_BYTE)) begin fails++; $display("FAIL rand_err%0d got %b exp %b", k, err_o, r == NAK_BYTE); end
      idle(int'($urandom_range(5, 0)));
    end
    tests++;
    if (got_tx.size() != exp_tx.size()) begin fails++; $display("FAIL rand_resp_count got %0d exp %0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin
      tests++;
      if (got_tx[i] !== exp_tx[i]) begin fails++; $display("FAIL rand_resp%0d got %h exp %h", i, got_tx[i], exp_tx[i]); end
    end
    tests++;
    if (got_w.size() != exp_w.size()) begin fails++; $display("FAIL rand_write_count got %0d exp %0d", got_w.size(), exp_w.size()); end
    else foreach (exp_w[i]) begin
      tests++;
      if (got_w[i].c !== exp_w[i].c || got_w[i].a !== exp_w[i].a || got_w[i].d !== exp_w[i].d)
        begin fails++; $display("FAIL rand_write%0d got c%0d a%h d%h exp c%0d a%h d%h", i, got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] r;
    clear_q();
    send_frame(12'hF80, 8'd0, 1'b0, 0, 0, r);
    exp_tx.push_back(r);
    wait_tx(0);
    send_frame(12'h123, 8'd3, 1'b0, 0, 0, r);
    exp_tx.push_back(r);
    wait_tx(1);
    tests += 2;
    if (got_tx.size() != 2 || got_tx[0] !== exp_tx[0] || got_tx[1] !== exp_tx[1])
      begin fails++; $display("FAIL b2b_resp got n=%0d exp 2 ACKs", got_tx.size()); end
    if (got_w.size() != exp_w.size()) begin fails++; $display("FAIL b2b_write_count got %0d exp %0d", got_w.size(), exp_w.size()); end
    else foreach (exp_w[i]) begin
      tests++;
      if (got_w[i].c !== exp_w[i].c || got_w[i].a !== exp_w[i].a || got_w[i].d !== exp_w[i].d)
        begin fails++; $display("FAIL b2b_write%0d got c%0d a%h d%h exp c%0d a%h d%h", i, got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d); end
    end
  endtask
  task automatic test_eop;
    logic [7:0] r;
    int c;
    clear_q();
    send_byte(EOP_DEFAULT, c);
    wait_tx(0);
    idle(3);
    tests += 2;
    if (got_tx.size() != 1 || got_tx[0] !== ACK_BYTE) begin fails++; $display("FAIL eop_ack got n=%0d exp one 06", got_tx.size()); end
    if (reset_o !== 1'b0) begin fails++; $display("FAIL eop_hold_reset got %b exp 0", reset_o); end
    prog_i = 1'b0;
    idle(3);
    tests++;
    if (reset_o !== 1'b1) begin fails++; $display("FAIL eop_close got %b exp 1", reset_o); end
    clear_q();
    send_frame(12'h050, 8'd1, 1'b0, 0, 2, r);
    idle(10);
    tests += 3;
    if (got_w.size() != 0) begin fails++; $display("FAIL nosess_write got n=%0d exp 0", got_w.size()); end
    if (got_tx.size() != 0) begin fails++; $display("FAIL nosess_resp got n=%0d exp 0", got_tx.size()); end
    if (reset_o !== 1'b1) begin fails++; $display("FAIL nosess_reset_o got %b exp 1", reset_o); end
  endtask
  task automatic test_reset_mid;
    int c;
    prog_i = 1'b1;
    idle(3);
    clear_q();
    send_byte(SOF_DEFAULT, c);
    send_byte(8'h00, c);
    send_byte(8'h20, c);
    send_byte(8'h01, c);
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    rst_ni = 1'b0;
    idle(1);
    tests += 4;
    if (reset_o !== 1'b0) begin fails++; $display("FAIL mid_reset_o got %b exp 0", reset_o); end
    if (bus.tx_byte_o !== 8'd0) begin fails++; $display("FAIL mid_txbyte got %h exp 00", bus.tx_byte_o); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL mid_err got %b exp 0", err_o); end
    if (bus.addr_o !== 12'd0) begin fails++; $display("FAIL mid_addr got %h exp 000", bus.addr_o); end
    rst_ni = 1'b1;
    send_byte(8'h33, c);
    send_byte(8'h44, c);
    idle(6);
    tests += 3;
    if (got_w.size() != 0) begin fails++; $display("FAIL mid_no_write got n=%0d exp 0", got_w.size()); end
    if (got_tx.size() != 0) begin fails++; $display("FAIL mid_no_resp got n=%0d exp 0", got_tx.size()); end
    if (reset_o !== 1'b0) begin fails++; $display("FAIL mid_session_reset_o got %b exp 0", reset_o); end
  endtask
  initial begin
    test_reset();
    test_open();
    test_basic();
    test_bad_cksum();
    test_wrap();
    test_busy();
    test_timeout();
    test_random();
    test_back_to_back();
    test_eop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
